// File: rtl/io_timer.sv
// Wishbone B4 classic machine timer: 64-bit mtime/mtimecmp, msip, level interrupts.
// Optional mtime prescaler enabled by defining IO_TIMER_PRESCALER_EN.
module io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_addr,
  input  logic [31:0] wbs_dat_w,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_we,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  output logic [31:0] wbs_dat_r,
  output logic        wbs_ack,
  output logic        wbs_err,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam logic [3:0] OFF_MTIME_LO = 4'd0;
  localparam logic [3:0] OFF_MTIME_HI = 4'd1;
  localparam logic [3:0] OFF_CMP_LO   = 4'd2;
  localparam logic [3:0] OFF_CMP_HI   = 4'd3;
  localparam logic [3:0] OFF_MSIP     = 4'd4;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_prescale_range
    $error("io_timer: PRESCALE must be within 1..65535");
  end

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;
  logic        r_tirq;

  logic        w_req;
  logic        w_hit;
  logic        w_map;
  logic [3:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_mlo;
  logic        w_wr_mhi;
  logic        w_wr_clo;
  logic        w_wr_chi;
  logic        w_wr_msip;
  logic        w_tick;
  logic [63:0] w_mtime_inc;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Handshake masks the request while a response is on the bus, forcing a gap cycle.
  assign w_req = wbs_cyc & wbs_stb & ~r_ack & ~r_err;
  assign w_hit = (wbs_addr[31:6] == BASE_ADDR[31:6]);
  assign w_off = wbs_addr[5:2];
  assign w_map = w_hit & (w_off <= OFF_MSIP);
  assign w_wr  = w_req & w_map & wbs_we & (|wbs_sel);
  assign w_rd  = w_req & w_map & ~wbs_we;

  assign w_wr_mlo  = w_wr & (w_off == OFF_MTIME_LO);
  assign w_wr_mhi  = w_wr & (w_off == OFF_MTIME_HI);
  assign w_wr_clo  = w_wr & (w_off == OFF_CMP_LO);
  assign w_wr_chi  = w_wr & (w_off == OFF_CMP_HI);
  assign w_wr_msip = w_wr & (w_off == OFF_MSIP) & wbs_sel[0];

  assign w_unused = &{1'b0, wbs_addr[1:0]};

`ifdef IO_TIMER_PRESCALER_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_pre;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= 16'd0;
    end else if (w_wr_mlo | w_wr_mhi | w_tick) begin
      r_pre <= 16'd0;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Carry into an unwritten half comes from the pre-write value.
  assign w_mtime_inc = r_mtime + {63'd0, w_tick};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime <= 64'd0;
    end else begin
      r_mtime[31:0]  <= w_wr_mlo ? f_merge(r_mtime[31:0], wbs_dat_w, wbs_sel)
                                 : w_mtime_inc[31:0];
      r_mtime[63:32] <= w_wr_mhi ? f_merge(r_mtime[63:32], wbs_dat_w, wbs_sel)
                                 : w_mtime_inc[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr_clo) r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], wbs_dat_w, wbs_sel);
      if (w_wr_chi) r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wbs_dat_w, wbs_sel);
      if (w_wr_msip) r_msip <= wbs_dat_w[0];
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      OFF_MTIME_LO: w_rdata = r_mtime[31:0];
      OFF_MTIME_HI: w_rdata = r_mtime[63:32];
      OFF_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      OFF_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      OFF_MSIP:     w_rdata = {31'd0, r_msip};
      default:      w_rdata = 32'd0;
    endcase
  end

  // Response stage: one-cycle ack/err pulse, read data held until the next read or error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_dat  <= 32'd0;
      r_tirq <= 1'b0;
    end else begin
      r_ack  <= w_req & w_map;
      r_err  <= w_req & ~w_map;
      r_tirq <= (r_mtime >= r_mtimecmp);
      if (w_req & ~w_map) begin
        r_dat <= 32'd0;
      end else if (w_rd) begin
        r_dat <= w_rdata;
      end
    end
  end

  assign wbs_ack   = r_ack;
  assign wbs_err   = r_err;
  assign wbs_dat_r = r_dat;
  assign timer_irq = r_tirq;
  assign soft_irq  = r_msip;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: per-cycle reference model plus directed literal checks.
module tb_io_timer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int TB_PRESCALE = 4;
`ifdef IO_TIMER_PRESCALER_EN
  localparam int P = TB_PRESCALE;
`else
  localparam int P = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wbs_addr = '0;
  logic [31:0] wbs_dat_w = '0;
  logic [3:0]  wbs_sel = '0;
  logic        wbs_we = 1'b0;
  logic        wbs_cyc = 1'b0;
  logic        wbs_stb = 1'b0;
  logic [31:0] wbs_dat_r;
  logic        wbs_ack;
  logic        wbs_err;
  logic        timer_irq;
  logic        soft_irq;

  io_timer #(.BASE_ADDR(BASE), .PRESCALE(TB_PRESCALE)) dut (
    .clk(clk), .rst(rst),
    .wbs_addr(wbs_addr), .wbs_dat_w(wbs_dat_w), .wbs_sel(wbs_sel),
    .wbs_we(wbs_we), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb),
    .wbs_dat_r(wbs_dat_r), .wbs_ack(wbs_ack), .wbs_err(wbs_err),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: mtime = base + elapsed/P since the last software write.
  logic [63:0] m_base = '0;
  int          m_age = 0;
  logic [63:0] m_cmp = '1;
  logic        m_msip = 1'b0;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;
  logic        m_tirq = 1'b0;
  logic [31:0] m_dat = '0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  initial begin : model
    logic [63:0] cur, inc, nv;
    logic        req, map, tick;
    logic [3:0]  off;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_base = '0; m_age = 0; m_cmp = '1; m_msip = 0;
        m_ack = 0; m_err = 0; m_tirq = 0; m_dat = '0;
      end else begin
        req  = wbs_cyc && wbs_stb && !m_ack && !m_err;
        off  = wbs_addr[5:2];
        map  = (wbs_addr[31:6] == BASE[31:6]) && (off <= 4);
        cur  = m_base + 64'(m_age / P);
        tick = ((m_age % P) == P - 1);
        inc  = cur + 64'(tick);
        m_tirq = (cur >= m_cmp);
        if (req && !map) m_dat = '0;
        else if (req && !wbs_we) begin
          case (off)
            4'd0: m_dat = cur[31:0];
            4'd1: m_dat = cur[63:32];
            4'd2: m_dat = m_cmp[31:0];
            4'd3: m_dat = m_cmp[63:32];
            default: m_dat = {31'd0, m_msip};
          endcase
        end
        if (req && map && wbs_we && wbs_sel != 0 && off <= 1) begin
          nv = inc;
          if (off == 0) nv[31:0] = lanes(cur[31:0], wbs_dat_w, wbs_sel);
          else          nv[63:32] = lanes(cur[63:32], wbs_dat_w, wbs_sel);
          m_base = nv;
          m_age = 0;
        end else begin
          m_age++;
        end
        if (req && map && wbs_we) begin
          if (off == 2) m_cmp[31:0]  = lanes(m_cmp[31:0], wbs_dat_w, wbs_sel);
          if (off == 3) m_cmp[63:32] = lanes(m_cmp[63:32], wbs_dat_w, wbs_sel);
          if (off == 4 && wbs_sel[0]) m_msip = wbs_dat_w[0];
        end
        m_ack = req && map;
        m_err = req && !map;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cmp_ack", 64'(wbs_ack), 64'(m_ack));
        chk("cmp_err", 64'(wbs_err), 64'(m_err));
        chk("cmp_dat", 64'(wbs_dat_r), 64'(m_dat));
        chk("cmp_tirq", 64'(timer_irq), 64'(m_tirq));
        chk("cmp_sirq", 64'(soft_irq), 64'(m_msip));
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  logic [31:0] l_rd;
  logic        l_a, l_e;

  // mode 0: plain; 1: drop cyc while the response is pending; 2: hold stb for a second access
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                     input logic [3:0] sel, input int mode,
                     output logic [31:0] rdat, output logic a, output logic e);
    @(negedge clk);
    wbs_addr = addr; wbs_dat_w = dat; wbs_sel = sel; wbs_we = we;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    if (mode == 1) begin
      @(posedge clk); #1;
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
    end
    @(negedge clk);
    if (mode == 2) repeat (2) @(negedge clk);
    rdat = wbs_dat_r; a = wbs_ack; e = wbs_err;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic wr(input int off, input logic [31:0] dat, input logic [3:0] sel);
    bus(1'b1, BASE + 32'(off * 4), dat, sel, 0, l_rd, l_a, l_e);
  endtask

  task automatic rd(input int off);
    bus(1'b0, BASE + 32'(off * 4), 32'd0, 4'hF, 0, l_rd, l_a, l_e);
  endtask

  initial begin : stim
    logic [31:0] v1, v2, addr;
    int unsigned c0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(wbs_ack), 64'd0);
    chk("rst_err", 64'(wbs_err), 64'd0);
    chk("rst_dat", 64'(wbs_dat_r), 64'd0);
    chk("rst_tirq", 64'(timer_irq), 64'd0);
    chk("rst_sirq", 64'(soft_irq), 64'd0);
    rst = 1'b1;

    // mtime advance between two reads
    wr(0, 32'd0, 4'hF);
    rd(0); v1 = l_rd;
    chk("t1_ack", 64'(l_a), 64'd1);
    chk("t1_err", 64'(l_e), 64'd0);
    chk("t1_first", 64'(v1), 64'(1 / P));
    repeat (10) @(negedge clk);
    rd(0); v2 = l_rd;
    chk("t1_delta", 64'(v2 - v1), 64'(13 / P - 1 / P));

    // timer interrupt rise and fall
    wr(1, 32'd0, 4'hF);
    wr(3, 32'd0, 4'hF);
    wr(2, 32'd100, 4'hF);
    wr(0, 32'd0, 4'hF);
    c0 = cyc;
    for (int i = 0; i < 1000 && !timer_irq; i++) @(negedge clk);
    chk("t2_rise_cycles", 64'(cyc - c0), 64'(100 * P + 1));
    wr(2, 32'hFFFF_FFFF, 4'hF);
    chk("t2_hold", 64'(timer_irq), 64'd1);
    @(negedge clk);
    chk("t2_fall", 64'(timer_irq), 64'd0);

    // carry from low half and full 64-bit wrap
    wr(1, 32'd0, 4'hF);
    wr(0, 32'hFFFF_FFFC, 4'hF);
    repeat (20 * P) @(negedge clk);
    rd(1);
    chk("t3_hi_carry", 64'(l_rd), 64'd1);
    rd(0);
    chk("t3_lo_small", 64'(l_rd < 32'd64), 64'd1);
    wr(1, 32'hFFFF_FFFF, 4'hF);
    wr(0, 32'hFFFF_FFFF, 4'hF);
    repeat (P) @(negedge clk);
    rd(1);
    chk("t3_wrap_hi", 64'(l_rd), 64'd0);

    // msip lane handling
    wr(4, 32'hFFFF_FFFF, 4'b0001);
    chk("t4_sirq_set", 64'(soft_irq), 64'd1);
    rd(4);
    chk("t4_readback", 64'(l_rd), 64'd1);
    wr(4, 32'd0, 4'b0000);
    chk("t4_sel0_ack", 64'(l_a), 64'd1);
    chk("t4_sel0_keep", 64'(soft_irq), 64'd1);
    wr(4, 32'd0, 4'b1110);
    chk("t4_upper_lanes", 64'(soft_irq), 64'd1);

    // error responses
    rd(5);
    chk("t5_err", 64'(l_e), 64'd1);
    chk("t5_noack", 64'(l_a), 64'd0);
    chk("t5_dat0", 64'(l_rd), 64'd0);
    @(negedge clk);
    chk("t5_err_pulse", 64'(wbs_err), 64'd0);
    bus(1'b1, BASE + 32'h40, 32'd0, 4'hF, 0, l_rd, l_a, l_e);
    chk("t5_oob_err", 64'(l_e), 64'd1);
    bus(1'b1, BASE + 32'h48, 32'd0, 4'hF, 0, l_rd, l_a, l_e);
    bus(1'b1, BASE + 32'h3C, 32'd0, 4'hF, 0, l_rd, l_a, l_e);
    chk("t5_off15_err", 64'(l_e), 64'd1);
    rd(2);
    chk("t5_cmp_lo_kept", 64'(l_rd), 64'hFFFF_FFFF);

    // reset during a pending response
    wr(3, 32'd0, 4'hF);
    wr(2, 32'd0, 4'hF);
    @(negedge clk);
    wbs_addr = BASE; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_cyc = 1'b1; wbs_stb = 1'b1;
    @(posedge clk); #1;
    chk("t6_ack_pending", 64'(wbs_ack), 64'd1);
    chk("t6_tirq_before", 64'(timer_irq), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_ack_cancel", 64'(wbs_ack), 64'd0);
    chk("t6_err", 64'(wbs_err), 64'd0);
    chk("t6_tirq", 64'(timer_irq), 64'd0);
    chk("t6_sirq", 64'(soft_irq), 64'd0);
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_ack_held", 64'(wbs_ack), 64'd0);
    rst = 1'b1;
    rd(3);
    chk("t6_cmp_hi", 64'(l_rd), 64'hFFFF_FFFF);
    rd(2);
    chk("t6_cmp_lo", 64'(l_rd), 64'hFFFF_FFFF);
    rd(1);
    chk("t6_mtime_hi", 64'(l_rd), 64'd0);
    chk("t6_tirq_after", 64'(timer_irq), 64'd0);

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 15))
        0: addr = $urandom;
        1: addr = BASE + 32'h40 + 32'($urandom_range(0, 63));
        default: addr = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      endcase
      bus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), l_rd, l_a, l_e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Wishbone B4 classic slave on the CPU's io port, directly downstream of the core.
- Holds a 64-bit free-running machine timer (mtime), a 64-bit compare register (mtimecmp) and a software-interrupt bit (msip).
- Drives the timer and software interrupt lines back into the core's interrupts vector.
- Single-cycle registered ack; unmapped offsets return err.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the block (64-byte aligned).
- PRESCALE, 1, clk cycles per mtime tick. Honoured only with IO_TIMER_PRESCALER_EN; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- wbs_addr  input  32  byte address
- wbs_dat_w  input  32  write data
- wbs_sel  input  4  byte lane enables
- wbs_we  input  1  write enable
- wbs_cyc  input  1  bus cycle
- wbs_stb  input  1  strobe
- wbs_dat_r  output  32  read data
- wbs_ack  output  1  transfer acknowledge
- wbs_err  output  1  transfer error
- timer_irq  output  1  machine timer interrupt, level
- soft_irq  output  1  machine software interrupt, level

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst=0, asynchronous), holds until rst=1:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - wbs_ack=0, wbs_err=0, wbs_dat_r=0, timer_irq=0, soft_irq=0, prescaler count=0.
- Request: req = wbs_cyc & wbs_stb & ~wbs_ack & ~wbs_err.
- Address decode:
  - hit when wbs_addr[31:6]==BASE_ADDR[31:6]; offset = wbs_addr[5:2]; wbs_addr[1:0] ignored.
  - Offset map: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 msip (bit 0, bits 31:1 read 0).
  - Any other offset, or no hit, is an error.
- Response timing (cycle after req): exactly one of wbs_ack or wbs_err pulses high for one cycle, then drops.
  - Next req is accepted no earlier than the cycle after the pulse, so each access takes at least 2 cycles.
- Reads: wbs_dat_r is registered with the ack; it holds the register value sampled in the req cycle and keeps its value until the next ack. Error reads return 0.
- Writes:
  - Performed in the req cycle, byte lanes per wbs_sel; sel=0 is acked with no effect.
  - Error writes are dropped.
  - msip: only bit 0 is writable, via lane 0.
- mtime tick:
  - Without the optional feature, mtime increments by 1 every cycle, 64-bit wrap FFFF_FFFF_FFFF_FFFF -> 0.
  - A software write to either mtime half takes precedence over the increment in that cycle. The unwritten half still receives the carry from that increment, computed on the pre-write value.
- timer_irq: registered, = (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the current register values each cycle.
  - Asserts 1 cycle after the condition becomes true; deasserts 1 cycle after a mtimecmp or mtime write makes it false.
  - No latching.
- soft_irq: = msip (register output directly).
- wbs_cyc dropped while the ack is pending: the ack/err still pulses once and the master ignores it. No state is rolled back.
- Reset asserted mid-transaction: the pending ack/err is cancelled immediately (async) and registers revert.

Optional Feature:
- Macro: IO_TIMER_PRESCALER_EN.
- Defined:
  - A 16-bit prescaler counts 0..PRESCALE-1; mtime increments on the cycle the count wraps to 0.
  - Any write to mtime clears the prescaler to 0.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; PRESCALE is ignored; mtime ticks every cycle.

Test Plan:
- Reset release, read offset 0 twice 10 cycles apart -> second value minus first = 10 + access spacing in cycles; ack 1 cycle after stb; wbs_err=0.
- Write mtimecmp_hi=0, mtimecmp_lo=100 with mtime near 0 -> timer_irq rises on the cycle after mtime reaches 100. Then write mtimecmp_lo=FFFF_FFFF -> timer_irq falls 1 cycle after the write ack.
- Write mtime_lo=FFFF_FFF0, mtime_hi=0 -> after 20 cycles mtime_hi reads 1 and mtime_lo reads a small value (carry propagated); full 64-bit wrap from all-ones gives 0.
- Write msip=32'hFFFF_FFFF with sel=4'b0001 -> soft_irq=1 and readback=1. Write msip=0 with sel=4'b0000 -> soft_irq stays 1.
- Access offset 5 (addr BASE_ADDR+0x14) and address BASE_ADDR+0x40 -> wbs_err single pulse, no ack, dat_r=0, no register changes.
- Assert rst low mid-access (cycle of req) -> ack never appears, mtime=0, mtimecmp all ones, timer_irq=0. With IO_TIMER_PRESCALER_EN and PRESCALE=4, mtime advances 1 per 4 cycles.
